apb_master_arbiter: RTL

Shares one APB master port among NUM_REQ requester agents in the aligner core's register path. Arbitrates round-robin, sequences the APB SETUP/ACCESS phases, and returns read data and error status to the granted requester. Bounds slave wait states with a timeout so one hung slave cannot stall every requester.

---
 rtl/apb_arb_pkg.sv | 35 +++
 rtl/apb_rr_arbiter.sv | 47 ++++
 rtl/apb_master_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types and constants for the APB master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AY_APB_MAX_ADDR_WIDTH
`define AY_APB_MAX_ADDR_WIDTH 32
`endif
`ifndef AY_APB_MAX_DATA_WIDTH
`define AY_APB_MAX_DATA_WIDTH 32
`endif

package apb_arb_pkg;

   // APB transfer sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int DEF_NUM_REQ        = 2;
   localparam int ID_WIDTH           = $clog2(DEF_NUM_REQ);
   localparam int DEF_TIMEOUT_CYCLES = 16;

   // Requester-index width for an arbitrary requester count (at least 1 bit)
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Combinational round-robin picker. Grants the first asserted
//               request at or after the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   input  logic                       en_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
   output logic                       gnt_valid_o
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0] cand_idx;
   logic            found;

   // Scan requesters starting at the pointer; the first hit wins
   always_comb begin
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      cand_idx    = '0;
      found       = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
         if (en_i && !found && req_i[cand_idx]) begin
            gnt_o[cand_idx] = 1'b1;
            gnt_idx_o       = cand_idx;
            found           = 1'b1;
         end
      end
      gnt_valid_o = found;
   end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// Module      : apb_master_arbiter
// Description : Shares one APB master port among NUM_REQ requesters with
//               round-robin arbitration, SETUP/ACCESS sequencing, response
//               return and a wait-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AY_APB_MAX_ADDR_WIDTH
`define AY_APB_MAX_ADDR_WIDTH 32
`endif
`ifndef AY_APB_MAX_DATA_WIDTH
`define AY_APB_MAX_DATA_WIDTH 32
`endif

module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int ADDR_WIDTH     = `AY_APB_MAX_ADDR_WIDTH,
   parameter int DATA_WIDTH     = `AY_APB_MAX_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                             clk,
   input  logic                             preset_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic                             rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_slverr,
   output logic                             rsp_timeout,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic                             pwrite,
   output logic                             psel,
   output logic                             penable,
   output logic [DATA_WIDTH-1:0]            pwdata,
   input  logic                             pready,
   input  logic [DATA_WIDTH-1:0]            prdata,
   input  logic                             pslverr
);

   localparam int ID_W   = id_width(NUM_REQ);
   localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCNT_W-1:0] c_tcnt_last =
      TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit c_tmo_en = (TIMEOUT_CYCLES != 0);

   apb_state_e                state_q, state_d;
   logic [ID_W-1:0]           ptr_q, ptr_d;
   logic [ID_W-1:0]           owner_q, owner_d;
   logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
   logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_slverr_q, rsp_slverr_d;
   logic                      rsp_timeout_q, rsp_timeout_d;

   logic [NUM_REQ-1:0]        gnt;
   logic [ID_W-1:0]           gnt_idx;
   logic                      gnt_valid;
   logic                      arb_en;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic [DATA_WIDTH-1:0]     sel_wdata;
   logic                      sel_write;

   assign arb_en = (state_q == ST_IDLE);

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .en_i        (arb_en),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // Accept pulse only exists while the sequencer is idle
   assign req_ready = gnt;

   // Route the granted requester's payload toward the APB capture registers
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_write = req_write[i];
         end
      end
   end

   // Next-state and registered-output logic for the APB sequencer
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      tcnt_d        = tcnt_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pwrite_d      = pwrite_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      rsp_valid_d   = 1'b0;
      rsp_id_d      = rsp_id_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
      rsp_timeout_d = rsp_timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               paddr_d   = sel_addr;
               pwdata_d  = sel_wdata;
               pwrite_d  = sel_write;
               owner_d   = gnt_idx;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               tcnt_d        = '0;
               rsp_valid_d   = 1'b1;
               rsp_id_d      = owner_q;
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_slverr_d  = pslverr;
               rsp_timeout_d = 1'b0;
               state_d       = ST_IDLE;
            end else if (c_tmo_en && (tcnt_q == c_tcnt_last)) begin
               // Slave exceeded its wait-state budget: abort with an error
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               tcnt_d        = '0;
               rsp_valid_d   = 1'b1;
               rsp_id_d      = owner_q;
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            tcnt_d    = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         tcnt_q        <= '0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         tcnt_q        <= tcnt_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign pwrite      = pwrite_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_slverr  = rsp_slverr_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire
